// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, engine states and gradient helpers for the Sobel magnitude stage
package sobel_pkg;
    localparam int CONV_W           = 29;
    localparam int SQ_IN_W          = 60;
    localparam int SQ_OUT_W         = SQ_IN_W / 2;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int WINDOW_COUNT_DEF = 9;

    typedef enum logic [1:0] {IDLE, RUN, OUT} eng_state_t;

    // |v| fits in CONV_W unsigned bits, including the most negative input
    function automatic logic [CONV_W-1:0] abs_grad(input logic signed [CONV_W-1:0] v);
        return v[CONV_W-1] ? CONV_W'(-v) : CONV_W'(v);
    endfunction
endpackage

// File: rtl/sobel_mag_scheduler_if.sv
// sobel_mag_scheduler_if: gradient inputs, back-pressure and magnitude handshake
interface sobel_mag_scheduler_if;
    import sobel_pkg::*;
    logic                      conv_ready_x;
    logic signed [CONV_W-1:0]  edge_data_in_x;
    logic                      conv_ready_y;
    logic signed [CONV_W-1:0]  edge_data_in_y;
    logic                      stall;
    logic                      edge_valid;
    logic                      edge_ready;
    logic [SQ_OUT_W-1:0]       edge_data;
    logic                      overflow;
    logic                      align_err;
    logic                      done;
    modport master (
        output conv_ready_x, edge_data_in_x, conv_ready_y, edge_data_in_y, edge_ready,
        input  stall, edge_valid, edge_data, overflow, align_err, done
    );
    modport slave (
        input  conv_ready_x, edge_data_in_x, conv_ready_y, edge_data_in_y, edge_ready,
        output stall, edge_valid, edge_data, overflow, align_err, done
    );
endinterface

// File: rtl/sqrt_iter.sv
// sqrt_iter: restoring integer square root, one result bit per cycle, MSB first
module sqrt_iter
    import sobel_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                busy,
    input  logic [SQ_IN_W-1:0]  radicand,
    output logic [SQ_OUT_W-1:0] root
);
    logic [SQ_IN_W-1:0]  rad;
    logic [SQ_OUT_W+1:0] rem;
    logic                ge;

    // trial subtract of (4*root + 1) from the remainder with the next two radicand bits
    always_comb begin
        ge = {rem, rad[SQ_IN_W-1 -: 2]} >= {2'b00, root, 2'b01};
    end

    // load on start, then step once per cycle while the scheduler holds busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rad  <= '0;
            rem  <= '0;
            root <= '0;
        end else if (start) begin
            rad  <= radicand;
            rem  <= '0;
            root <= '0;
        end else if (busy) begin
            rad  <= rad << 2;
            rem  <= (SQ_OUT_W+2)'(ge ? {rem, rad[SQ_IN_W-1 -: 2]} - {2'b00, root, 2'b01}
                                     : {rem, rad[SQ_IN_W-1 -: 2]});
            root <= {root[SQ_OUT_W-2:0], ge};
        end
    end
endmodule

// File: rtl/sobel_mag_scheduler.sv
// sobel_mag_scheduler: pairs x/y gradients, queues x^2+y^2 and schedules the shared sqrt engine
module sobel_mag_scheduler
    import sobel_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int WINDOW_COUNT = WINDOW_COUNT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    sobel_mag_scheduler_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int NW = $clog2(WINDOW_COUNT + 1);
    localparam int IW = $clog2(SQ_OUT_W);

    logic signed [CONV_W-1:0] hold_x, hold_y;
    logic                     hold_x_v, hold_y_v;
    logic [SQ_IN_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic [NW-1:0]            results;
    logic [IW-1:0]            iter;
    eng_state_t               state, state_nx;
    logic [2*CONV_W-1:0]      ax, ay;
    logic [SQ_IN_W-1:0]       sum_sq;
    logic [SQ_OUT_W-1:0]      root;
    logic                     pair, full, push, pop, hs;

    assign pair       = hold_x_v && hold_y_v;
    assign full       = count == CW'(FIFO_DEPTH);
    assign push       = pair && !full;
    assign pop        = state == IDLE && count != '0;
    assign hs         = state == OUT && bus.edge_ready;
    assign ax         = (2*CONV_W)'(abs_grad(hold_x));
    assign ay         = (2*CONV_W)'(abs_grad(hold_y));
    assign sum_sq     = SQ_IN_W'(ax * ax + ay * ay);
    assign bus.stall  = count >= CW'(FIFO_DEPTH - 1);

    // hold registers keep the first arrival; a repeat before pairing is dropped and flagged
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_x        <= '0;
            hold_y        <= '0;
            hold_x_v      <= 1'b0;
            hold_y_v      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.align_err <= 1'b0;
        end else begin
            if (bus.conv_ready_x && !hold_x_v) hold_x <= bus.edge_data_in_x;
            if (bus.conv_ready_y && !hold_y_v) hold_y <= bus.edge_data_in_y;
            hold_x_v      <= !pair && (hold_x_v || bus.conv_ready_x);
            hold_y_v      <= !pair && (hold_y_v || bus.conv_ready_y);
            bus.overflow  <= bus.overflow || (pair && full);
            bus.align_err <= bus.align_err || (bus.conv_ready_x && hold_x_v)
                                           || (bus.conv_ready_y && hold_y_v);
        end
    end

    // radicand storage; occupancy lives in count so the array needs no reset
    always_ff @(posedge clk) begin
        if (push) fifo_mem[rd_ptr + count[PW-1:0]] <= sum_sq;
    end

    // queue pointers, engine state, iteration and frame completion tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            count    <= '0;
            state    <= IDLE;
            iter     <= '0;
            results  <= '0;
            bus.done <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr + PW'(pop);
            count    <= count + CW'(push) - CW'(pop);
            state    <= state_nx;
            iter     <= pop ? IW'(SQ_OUT_W - 1) : state == RUN ? iter - IW'(1) : iter;
            results  <= (hs && results != NW'(WINDOW_COUNT)) ? results + NW'(1) : results;
            bus.done <= bus.done || (hs && results == NW'(WINDOW_COUNT - 1));
        end
    end

    // engine sequencing and result presentation
    always_comb begin
        state_nx       = state;
        bus.edge_valid = 1'b0;
        bus.edge_data  = '0;
        state_nx       = (state == IDLE && pop)        ? RUN  :
                         (state == RUN && iter == '0)  ? OUT  :
                         hs                            ? IDLE : state;
        bus.edge_valid = state == OUT;
        bus.edge_data  = state == OUT ? root : '0;
    end

    sqrt_iter u_sqrt (
        .clk      (clk),
        .reset    (reset),
        .start    (pop),
        .busy     (state == RUN),
        .radicand (fifo_mem[rd_ptr]),
        .root     (root)
    );
endmodule
